// File: rtl/start_point_decoder.sv
// Receive-side trial sequencer and location-code decoder for the start-point generator.
// Optional malformed-code counter enabled by defining START_POINT_ERR_CNT_EN.
module start_point_decoder #(
    parameter int          N_TRIAL   = 260,
    parameter int          MAX_STEPS = 255,
    parameter logic [5:0]  GOAL_CODE = 6'b101000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        session_go,
    input  logic [5:0]  start_code,
    input  logic        code_valid,
    input  logic [5:0]  code_in,
    output logic [9:0]  iTrial,
    output logic        active,
    output logic        pos_valid,
    output logic        pos_axis,
    output logic [1:0]  pos_slot,
    output logic        code_err,
    output logic        start_err,
    output logic        trial_done,
    output logic        trial_hit,
    output logic        session_done,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [9:0] LAST_TRIAL = 10'(N_TRIAL - 1);
    localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

    function automatic logic code_legal(input logic [5:0] code);
        logic axis_ok;
        logic slot_ok;
        axis_ok = (code[5:4] == 2'b01) || (code[5:4] == 2'b10);
        slot_ok = (code[3:0] == 4'b0001) || (code[3:0] == 4'b0010) ||
                  (code[3:0] == 4'b0100) || (code[3:0] == 4'b1000);
        return axis_ok && slot_ok;
    endfunction

    function automatic logic [1:0] slot_index(input logic [3:0] slot);
        logic [1:0] idx;
        case (slot)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [7:0] steps_r;
    logic [7:0] steps_s;
    logic [9:0] itrial_r;
    logic [9:0] itrial_s;
    logic       hit_s;
    logic       run_beat_s;
    logic       legal_s;

    assign run_beat_s = (state_r == RUN) && code_valid;
    assign legal_s    = code_legal(code_in);
    assign iTrial     = itrial_r;

    // Next-state and trial bookkeeping
    always_comb begin
        state_s  = state_r;
        steps_s  = steps_r;
        itrial_s = itrial_r;
        hit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (session_go) begin
                    state_s  = LOAD;
                    itrial_s = 10'd0;
                end else begin
                    state_s  = IDLE;
                end
            end
            LOAD: begin
                state_s = RUN;
                steps_s = 8'd0;
            end
            RUN: begin
                if (code_valid) begin
                    steps_s = (steps_r == 8'hFF) ? steps_r : steps_r + 8'd1;
                    // Goal takes priority over a timeout on the same beat
                    if (legal_s && (code_in == GOAL_CODE)) begin
                        state_s = DONE;
                        hit_s   = 1'b1;
                    end else if (steps_s >= STEP_LIMIT) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (itrial_r == LAST_TRIAL) begin
                    state_s = IDLE;
                end else begin
                    state_s  = LOAD;
                    itrial_s = itrial_r + 10'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            steps_r      <= 8'd0;
            itrial_r     <= 10'd0;
            active       <= 1'b0;
            pos_valid    <= 1'b0;
            pos_axis     <= 1'b0;
            pos_slot     <= 2'd0;
            code_err     <= 1'b0;
            start_err    <= 1'b0;
            trial_done   <= 1'b0;
            trial_hit    <= 1'b0;
            session_done <= 1'b0;
        end else begin
            state_r      <= state_s;
            steps_r      <= steps_s;
            itrial_r     <= itrial_s;
            active       <= (state_s == LOAD) || (state_s == RUN);
            pos_valid    <= run_beat_s;
            pos_axis     <= run_beat_s && legal_s && code_in[5];
            pos_slot     <= (run_beat_s && legal_s) ? slot_index(code_in[3:0]) : 2'd0;
            code_err     <= run_beat_s && !legal_s;
            trial_done   <= (state_s == DONE);
            trial_hit    <= (state_s == DONE) && hit_s;
            session_done <= (state_s == DONE) && (itrial_r == LAST_TRIAL);
            if (state_r == LOAD) begin
                start_err <= !code_legal(start_code);
            end else if (state_s == LOAD) begin
                start_err <= 1'b0;
            end else begin
                start_err <= start_err;
            end
        end
    end

`ifdef START_POINT_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Saturating malformed-code counter, cleared when a session starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_r <= 8'd0;
        end else if ((state_r == IDLE) && session_go) begin
            err_cnt_r <= 8'd0;
        end else if (run_beat_s && !legal_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_count = err_cnt_r;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_start_point_decoder.sv
// Scoreboard bench for start_point_decoder: decode and trial outcomes are queued as
// stimulus is driven and compared when the DUT strobes pos_valid / trial_done.
module tb_start_point_decoder;

    localparam int         NT   = 6;
    localparam logic [5:0] GOAL = 6'b101000;

    logic        clk = 1'b0;
    logic        reset;
    logic        session_go;
    logic [5:0]  start_code;
    logic        code_valid;
    logic [5:0]  code_in;
    logic [9:0]  iTrial;
    logic        active;
    logic        pos_valid;
    logic        pos_axis;
    logic [1:0]  pos_slot;
    logic        code_err;
    logic        start_err;
    logic        trial_done;
    logic        trial_hit;
    logic        session_done;
    logic [7:0]  err_count;

    start_point_decoder #(.N_TRIAL(NT), .MAX_STEPS(255), .GOAL_CODE(GOAL)) dut (
        .clk(clk), .reset(reset), .session_go(session_go), .start_code(start_code),
        .code_valid(code_valid), .code_in(code_in), .iTrial(iTrial), .active(active),
        .pos_valid(pos_valid), .pos_axis(pos_axis), .pos_slot(pos_slot),
        .code_err(code_err), .start_err(start_err), .trial_done(trial_done),
        .trial_hit(trial_hit), .session_done(session_done), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] dec_q[$];
    logic       hit_q[$];
    int         steps_m  = 0;
    int         err_m    = 0;
    int         sess_cnt = 0;
    int         done_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_err_count();
`ifdef START_POINT_ERR_CNT_EN
        return (err_m > 255) ? 32'd255 : 32'(err_m);
`else
        return 32'd0;
`endif
    endfunction

    // One RUN beat: queue the expected decode (and trial outcome if it ends the trial)
    task automatic beat(input logic [5:0] c);
        logic       legal;
        logic [1:0] slot;
        legal = ((c[5:4] == 2'b01) || (c[5:4] == 2'b10)) && ($countones(c[3:0]) == 1);
        slot  = 2'd0;
        for (int b = 0; b < 4; b++) if (legal && c[b]) slot = 2'(b);
        dec_q.push_back({legal ? c[5] : 1'b0, slot, !legal});
        if (!legal) err_m++;
        steps_m++;
        if (legal && (c == GOAL)) hit_q.push_back(1'b1);
        else if (steps_m >= 255)  hit_q.push_back(1'b0);
        code_valid = 1'b1;
        code_in    = c;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {iTrial, active, pos_valid, pos_axis, pos_slot, code_err, start_err,
                       trial_done, trial_hit, session_done, err_count}, 32'd0);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (!reset) begin
            if (pos_valid) begin
                if (dec_q.size() == 0) check_eq("pos_valid_spurious", 32'd1, 32'd0);
                else check_eq("decode", {pos_axis, pos_slot, code_err}, dec_q.pop_front());
            end
            if (trial_done) begin
                done_cnt++;
                if (hit_q.size() == 0) check_eq("trial_done_spurious", 32'd1, 32'd0);
                else check_eq("trial_hit", trial_hit, hit_q.pop_front());
            end
            if (session_done) begin
                sess_cnt++;
                check_eq("session_done_last", iTrial, NT - 1);
                check_eq("session_done_with_trial_done", trial_done, 1);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset = 1'b1; session_go = 1'b0; code_valid = 1'b0; code_in = 6'd0; start_code = 6'd0;
        tick(); tick();
        check_all_zero("reset_outputs");
        reset = 1'b0;
        tick();
        check_eq("idle_inactive", active, 0);

        // Trial 0: decode patterns, malformed codes, goal
        start_code = 6'b010001; session_go = 1'b1; err_m = 0;
        tick();
        session_go = 1'b0;
        check_eq("load_active", active, 1);
        check_eq("load_itrial", iTrial, 0);
        tick(); steps_m = 0;
        check_eq("run_start_err_clear", start_err, 0);
        beat(6'b010001);
        check_eq("pos_valid_latency", pos_valid, 1);
        beat(6'b011000);
        beat(6'b100100);
        beat(6'b110001);
        beat(6'b010011);
        check_eq("err_count_two", err_count, exp_err_count());
        start_code = 6'b000000;
        beat(GOAL);
        check_eq("goal_done", {trial_done, trial_hit}, 2'b11);
        check_eq("goal_itrial_held", iTrial, 0);
        tick();
        check_eq("next_load", {active, trial_done, iTrial}, {2'b10, 10'd1});

        // Trial 1: malformed start code, step timeout
        tick(); steps_m = 0;
        check_eq("start_err_set", start_err, 1);
        repeat (254) beat(6'b010100);
        check_eq("start_err_held", start_err, 1);
        check_eq("no_early_timeout", trial_done, 0);
        start_code = 6'b010001;
        beat(6'b010100);
        check_eq("timeout_done", {trial_done, trial_hit}, 2'b10);
        tick();
        check_eq("start_err_cleared_load", start_err, 0);

        // Trial 2: goal on the last allowed beat
        tick(); steps_m = 0;
        repeat (254) beat(6'b010100);
        start_code = GOAL;
        beat(GOAL);
        check_eq("goal_last_beat", {trial_done, trial_hit}, 2'b11);

        // code_valid in DONE/LOAD is ignored; start code equal to goal does not end trial 3
        code_valid = 1'b1; code_in = GOAL;
        tick(); tick();
        code_valid = 1'b0; steps_m = 0;
        check_eq("trial3_run", {active, iTrial}, {1'b1, 10'd3});
        tick();
        check_eq("start_goal_no_end", trial_done, 0);
        beat(6'b100001);
        beat(GOAL);
        tick(); tick(); steps_m = 0;
        beat(GOAL);
        tick(); tick(); steps_m = 0;
        check_eq("trial5_itrial", iTrial, 5);
        beat(6'b100010);
        session_go = 1'b1;
        tick();
        session_go = 1'b0;
        check_eq("go_ignored_in_run", {active, iTrial}, {1'b1, 10'd5});

        // Asynchronous reset mid-RUN
        reset = 1'b1;
        #2;
        check_all_zero("reset_mid_run");
        err_m = 0;
        tick();
        reset = 1'b0;
        tick();
        check_eq("idle_after_reset", active, 0);

        // Full session with goal hits
        d0 = done_cnt;
        start_code = 6'b010010; session_go = 1'b1;
        tick();
        session_go = 1'b0;
        check_eq("restart_load", {active, iTrial}, {1'b1, 10'd0});
        tick(); steps_m = 0;
        beat(6'b110001);
        check_eq("err_count_after_reset", err_count, exp_err_count());
        for (int t = 0; t < NT; t++) begin
            beat(6'b011000);
            beat(GOAL);
            tick(); tick(); steps_m = 0;
        end
        check_eq("session_idle", active, 0);
        check_eq("session_itrial_held", iTrial, NT - 1);
        check_eq("session_done_once", sess_cnt, 1);
        check_eq("session_trial_count", done_cnt - d0, NT);
        check_eq("decode_queue_empty", dec_q.size(), 0);
        check_eq("hit_queue_empty", hit_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
